// File: rtl/song_follower_if.sv
// Play-along sequencer bus: control, pitch detector input, song ROM port and score/status outputs.
interface song_follower_if #(
  parameter int unsigned w_note  = 12,
  parameter int unsigned w_idx   = 6,
  parameter int unsigned w_score = 8
);
  logic               start;
  logic               abort;
  logic [w_note-1:0]  det_note;
  logic [w_idx-1:0]   rom_addr;
  logic [w_note-1:0]  rom_note;
  logic [w_idx-1:0]   cur_index;
  logic [w_note-1:0]  expected_note;
  logic               hit;
  logic               miss;
  logic [w_score-1:0] hits;
  logic [w_score-1:0] misses;
  logic               busy;
  logic               done;

  // Controller / environment side: drives control, detector and ROM data.
  modport master (
    output start, abort, det_note, rom_note,
    input  rom_addr, cur_index, expected_note, hit, miss, hits, misses, busy, done
  );

  // Sequencer side.
  modport slave (
    input  start, abort, det_note, rom_note,
    output rom_addr, cur_index, expected_note, hit, miss, hits, misses, busy, done
  );
endinterface

// File: rtl/song_follower.sv
// Play-along sequencer: walks a one-hot song ROM, waits for a released-then-matched
// detected note or a per-note timeout, and keeps saturating hit/miss scores.
module song_follower #(
  parameter int unsigned w_note         = 12,
  parameter int unsigned note_count     = 62,
  parameter int unsigned timeout_cycles = 50_000_000,
  parameter int unsigned w_score        = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  song_follower_if.slave bus
);
  localparam int unsigned w_idx   = $clog2(note_count);
  localparam int unsigned w_timer = $clog2(timeout_cycles + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_LISTEN, S_NEXT, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [w_idx-1:0]   rom_addr_q, rom_addr_d;
  logic [w_idx-1:0]   idx_q, idx_d;
  logic [w_note-1:0]  exp_q, exp_d;
  logic [w_timer-1:0] timer_q, timer_d;
  logic               armed_q, armed_d;
  logic [w_score-1:0] hits_q, hits_d;
  logic [w_score-1:0] misses_q, misses_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      idx_q      <= '0;
      exp_q      <= '0;
      timer_q    <= '0;
      armed_q    <= 1'b0;
      hits_q     <= '0;
      misses_q   <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      idx_q      <= idx_d;
      exp_q      <= exp_d;
      timer_q    <= timer_d;
      armed_q    <= armed_d;
      hits_q     <= hits_d;
      misses_q   <= misses_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // rom_addr is loaded on entry to FETCH so ROM data is ready during LOAD.
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    idx_d      = idx_q;
    exp_d      = exp_q;
    timer_d    = timer_q;
    armed_d    = armed_q;
    hits_d     = hits_q;
    misses_d   = misses_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;

    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            hits_d     = '0;
            misses_d   = '0;
            idx_d      = '0;
            rom_addr_d = '0;
            state_d    = S_FETCH;
          end
        end
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          exp_d   = bus.rom_note;
          timer_d = '0;
          armed_d = 1'b0;
          state_d = (bus.rom_note == '0) ? S_NEXT : S_LISTEN;
        end
        S_LISTEN: begin
          timer_d = timer_q + w_timer'(1);
          if (bus.det_note != exp_q) armed_d = 1'b1;
          // A match only counts after the note was released at least once.
          if (armed_q && (bus.det_note == exp_q)) begin
            hit_d   = 1'b1;
            if (hits_q != '1) hits_d = hits_q + w_score'(1);
            state_d = S_NEXT;
          end else if (timer_q == w_timer'(timeout_cycles - 1)) begin
            miss_d  = 1'b1;
            if (misses_q != '1) misses_d = misses_q + w_score'(1);
            state_d = S_NEXT;
          end
        end
        S_NEXT: begin
          if (idx_q == w_idx'(note_count - 1)) begin
            state_d = S_DONE;
          end else begin
            idx_d      = idx_q + w_idx'(1);
            rom_addr_d = idx_q + w_idx'(1);
            state_d    = S_FETCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_FETCH) || (state_d == S_LOAD) ||
             (state_d == S_LISTEN) || (state_d == S_NEXT);
    done_d = (state_d == S_DONE);
  end

  assign bus.rom_addr      = rom_addr_q;
  assign bus.cur_index     = idx_q;
  assign bus.expected_note = exp_q;
  assign bus.hit           = hit_q;
  assign bus.miss          = miss_q;
  assign bus.hits          = hits_q;
  assign bus.misses        = misses_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
endmodule

// File: tb/tb_song_follower.sv
// Bench for song_follower: directed play/timeout/repeat/rest/abort/reset/saturation scenarios
// plus random songs and detector streams, checked against an event-level song model.
module tb_song_follower;
  localparam int NC   = 4;
  localparam int T1   = 100;
  localparam int MAXC = 2000;
  localparam logic [11:0] N_E = 12'h080;
  localparam logic [11:0] N_G = 12'h010;
  localparam logic [11:0] N_D = 12'h200;
  localparam logic [11:0] N_C = 12'h800;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  song_follower_if #(.w_note(12), .w_idx(2), .w_score(8)) sf1 ();
  song_follower_if #(.w_note(12), .w_idx(3), .w_score(2)) sf2 ();

  song_follower #(.w_note(12), .note_count(NC), .timeout_cycles(T1), .w_score(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(sf1)
  );
  song_follower #(.w_note(12), .note_count(5), .timeout_cycles(20), .w_score(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(sf2)
  );

  logic [11:0] rom_m [NC];
  logic [11:0] rom2  [8];
  always @(posedge clk) sf1.rom_note <= rom_m[sf1.rom_addr];
  always @(posedge clk) sf2.rom_note <= rom2[sf2.rom_addr];

  int errors = 0;
  int checks = 0;

  logic [11:0] det_arr  [MAXC];
  bit          exp_hit  [MAXC];
  bit          exp_miss [MAXC];
  int          exp_idx  [MAXC];
  logic [11:0] exp_note [MAXC];
  int          done_c, m_hits, m_misses, obs_done_c;
  int          obs_hit_c[$];
  int          obs_miss_c[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Event-level song model: cycle 0 is the first FETCH after start is taken.
  task automatic predict();
    int pos, e, lst;
    bit armed;
    for (int c = 0; c < MAXC; c++) begin
      exp_hit[c] = 0; exp_miss[c] = 0; exp_idx[c] = 0; exp_note[c] = '0;
    end
    pos = 0; m_hits = 0; m_misses = 0;
    for (int i = 0; i < NC; i++) begin
      if (rom_m[i] == 12'h000) begin
        pos += 3;
      end else begin
        lst = pos + 2; armed = 0; e = lst + T1 - 1;
        for (int c = lst; c < lst + T1; c++) begin
          if (armed && det_arr[c] == rom_m[i]) begin
            e = c; exp_hit[c+1] = 1; m_hits++; break;
          end
          if (c == lst + T1 - 1) begin
            exp_miss[c+1] = 1; m_misses++; break;
          end
          if (det_arr[c] != rom_m[i]) armed = 1;
        end
        exp_idx[e+1] = i; exp_note[e+1] = rom_m[i];
        pos = e + 2;
      end
    end
    done_c = pos;
  endtask

  task automatic clear_det();
    for (int c = 0; c < MAXC; c++) det_arr[c] = '0;
  endtask

  // Release-then-play stimulus for every non-rest entry, fastest possible.
  task automatic build_play();
    int pos;
    clear_det();
    pos = 0;
    for (int i = 0; i < NC; i++) begin
      if (rom_m[i] == 12'h000) pos += 3;
      else begin det_arr[pos+3] = rom_m[i]; pos += 5; end
    end
  endtask

  function automatic logic [11:0] rand_onehot();
    logic [11:0] v;
    v = 12'h001 << $urandom_range(11, 0);
    return v;
  endfunction

  task automatic gen_random();
    int c, len, r;
    logic [11:0] v;
    for (int i = 0; i < NC; i++) begin
      r = $urandom_range(99, 0);
      if (r < 15) rom_m[i] = '0;
      else if (r < 35 && i > 0) rom_m[i] = rom_m[i-1];
      else rom_m[i] = rand_onehot();
    end
    c = 0;
    while (c < MAXC) begin
      len = $urandom_range(8, 1);
      r = $urandom_range(99, 0);
      if (r < 30) v = '0;
      else if (r < 80) v = rom_m[$urandom_range(NC-1, 0)];
      else v = rand_onehot();
      for (int k = 0; k < len && c < MAXC; k++) begin det_arr[c] = v; c++; end
    end
  endtask

  // Called #1 after an edge with DUT1 in IDLE or DONE; stop_c < 0 runs to DONE.
  task automatic run_song(input int stop_c);
    predict();
    obs_hit_c.delete(); obs_miss_c.delete(); obs_done_c = -1;
    sf1.start = 1'b1; sf1.det_note = '0;
    @(posedge clk); #1;
    sf1.start = 1'b0;
    for (int c = 0; c <= done_c; c++) begin
      sf1.det_note = det_arr[c];
      check("hit", 32'(sf1.hit), 32'(exp_hit[c]));
      check("miss", 32'(sf1.miss), 32'(exp_miss[c]));
      check("busy", 32'(sf1.busy), 32'(c < done_c));
      check("done", 32'(sf1.done), 32'(c >= done_c));
      if (exp_hit[c] || exp_miss[c]) begin
        check("pulse_index", 32'(sf1.cur_index), 32'(exp_idx[c]));
        check("pulse_note", 32'(sf1.expected_note), 32'(exp_note[c]));
      end
      if (sf1.hit === 1'b1) obs_hit_c.push_back(c);
      if (sf1.miss === 1'b1) obs_miss_c.push_back(c);
      if (sf1.done === 1'b1 && obs_done_c < 0) obs_done_c = c;
      if (c == stop_c) return;
      if (c < done_c) begin @(posedge clk); #1; end
    end
    check("end_hits", 32'(sf1.hits), 32'(m_hits));
    check("end_misses", 32'(sf1.misses), 32'(m_misses));
    check("end_index", 32'(sf1.cur_index), 32'(NC - 1));
    check("end_rom_addr", 32'(sf1.rom_addr), 32'(NC - 1));
    check("end_note", 32'(sf1.expected_note), 32'(rom_m[NC-1]));
  endtask

  initial begin
    int q, nmiss;
    rst_n = 1'b0;
    sf1.start = 1'b0; sf1.abort = 1'b0; sf1.det_note = '0;
    sf2.start = 1'b0; sf2.abort = 1'b0; sf2.det_note = '0;
    for (int i = 0; i < 8; i++) rom2[i] = N_E;
    rom_m[0] = N_E; rom_m[1] = N_G; rom_m[2] = N_D; rom_m[3] = N_C;
    #3;
    check("rst_rom_addr", 32'(sf1.rom_addr), 0);
    check("rst_index", 32'(sf1.cur_index), 0);
    check("rst_note", 32'(sf1.expected_note), 0);
    check("rst_flags", {28'd0, sf1.hit, sf1.miss, sf1.busy, sf1.done}, 0);
    check("rst_scores", {16'd0, sf1.hits, sf1.misses}, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Correct play
    build_play();
    run_song(-1);
    check("cp_hits", 32'(sf1.hits), 4);
    check("cp_misses", 32'(sf1.misses), 0);
    check("cp_done", 32'(sf1.done), 1);
    check("cp_index", 32'(sf1.cur_index), 3);
    check("cp_pulses", 32'(obs_hit_c.size()), 4);

    // Timeout on every note: miss 100 cycles after LISTEN entry, done 4*103 edges after start taken
    clear_det();
    run_song(-1);
    check("to_misses", 32'(sf1.misses), 4);
    check("to_hits", 32'(sf1.hits), 0);
    check("to_done_cycle", 32'(obs_done_c), 4 * 103);
    for (int k = 0; k < 4; k++) begin
      q = (k < obs_miss_c.size()) ? obs_miss_c[k] : -1;
      check("to_miss_cycle", 32'(q), 32'(103 * k + 102));
    end

    // Held E never satisfies two consecutive E entries without a release
    rom_m[0] = N_E; rom_m[1] = N_E; rom_m[2] = N_G; rom_m[3] = N_C;
    clear_det();
    for (int c = 0; c <= 10; c++) det_arr[c] = N_E;
    for (int c = 12; c <= 25; c++) det_arr[c] = N_E;
    det_arr[27] = N_E; det_arr[32] = N_G; det_arr[37] = N_C;
    run_song(-1);
    check("rep_hit0_cycle", 32'((obs_hit_c.size() > 0) ? obs_hit_c[0] : -1), 13);
    check("rep_hit1_cycle", 32'((obs_hit_c.size() > 1) ? obs_hit_c[1] : -1), 28);
    check("rep_hits", 32'(sf1.hits), 4);

    // Rest entry skipped
    rom_m[0] = N_E; rom_m[1] = '0; rom_m[2] = N_G; rom_m[3] = N_C;
    build_play();
    run_song(-1);
    check("rest_hits", 32'(sf1.hits), 3);
    check("rest_misses", 32'(sf1.misses), 0);
    check("rest_pulses", 32'(obs_hit_c.size() + obs_miss_c.size()), 3);

    // Abort at index 2 in the same cycle as the matching note
    rom_m[0] = N_E; rom_m[1] = N_G; rom_m[2] = N_D; rom_m[3] = N_C;
    build_play();
    run_song(13);
    check("ab_pre_index", 32'(sf1.cur_index), 2);
    check("ab_pre_hits", 32'(sf1.hits), 2);
    sf1.abort = 1'b1;
    @(posedge clk); #1;
    sf1.abort = 1'b0; sf1.det_note = '0;
    check("ab_hit", 32'(sf1.hit), 0);
    check("ab_busy", 32'(sf1.busy), 0);
    check("ab_done", 32'(sf1.done), 0);
    check("ab_hits", 32'(sf1.hits), 2);
    check("ab_misses", 32'(sf1.misses), 0);
    check("ab_index", 32'(sf1.cur_index), 2);
    check("ab_note", 32'(sf1.expected_note), 32'(N_D));
    sf1.start = 1'b1;
    @(posedge clk); #1;
    sf1.start = 1'b0;
    check("rs_rom_addr", 32'(sf1.rom_addr), 0);
    check("rs_hits", 32'(sf1.hits), 0);
    check("rs_misses", 32'(sf1.misses), 0);
    check("rs_busy", 32'(sf1.busy), 1);
    sf1.abort = 1'b1;
    @(posedge clk); #1;
    sf1.abort = 1'b0;
    check("rs_abort_busy", 32'(sf1.busy), 0);

    // Random songs and detector streams
    for (int r = 0; r < 8; r++) begin
      gen_random();
      run_song(-1);
    end

    // Asynchronous reset in the middle of LISTEN
    rom_m[0] = N_E; rom_m[1] = N_G; rom_m[2] = N_D; rom_m[3] = N_C;
    build_play();
    run_song(8);
    check("mid_hits", 32'(sf1.hits), 1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_rom_addr", 32'(sf1.rom_addr), 0);
    check("arst_index", 32'(sf1.cur_index), 0);
    check("arst_note", 32'(sf1.expected_note), 0);
    check("arst_flags", {28'd0, sf1.hit, sf1.miss, sf1.busy, sf1.done}, 0);
    check("arst_scores", {16'd0, sf1.hits, sf1.misses}, 0);
    @(posedge clk); #1; rst_n = 1'b1; sf1.det_note = '0;
    @(posedge clk); #1;

    // Miss counter saturation with a 2-bit score
    sf2.start = 1'b1;
    @(posedge clk); #1;
    sf2.start = 1'b0;
    nmiss = 0;
    for (int c = 0; c < 500 && sf2.done !== 1'b1; c++) begin
      if (sf2.miss === 1'b1) nmiss++;
      @(posedge clk); #1;
    end
    check("sat_done", 32'(sf2.done), 1);
    check("sat_pulses", 32'(nmiss), 5);
    check("sat_misses", 32'(sf2.misses), 3);
    check("sat_hits", 32'(sf2.hits), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/song_follower.md
Name: song_follower

Overview:
- Sequencer for a "play along" mode.
- Walks a song table stored in a synchronous ROM, one note per entry as a one-hot 12-bit note code (C..B).
- Waits for the thresholded note from the microphone pitch detector to match the expected note, or for a per-note timeout.
- Counts hits and misses; exposes the current index and expected note to the display/graphics logic.

Parameters:
- w_note, 12, width of one-hot note code (bit 11 = C ... bit 0 = B).
- note_count, 62, number of song entries.
- w_idx, $clog2(note_count), index/address width.
- timeout_cycles, 50_000_000, LISTEN cycles before a miss (1 s at 50 MHz).
- w_score, 8, width of hit/miss counters.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, level sampled per cycle; begins or restarts the song from IDLE/DONE.
- abort, input, 1, returns to IDLE from any state.
- det_note, input, w_note, thresholded detected note; 0 = no note.
- rom_addr, output, w_idx, song ROM address, registered.
- rom_note, input, w_note, ROM data, valid 1 cycle after rom_addr.
- cur_index, output, w_idx, index of the note being listened for.
- expected_note, output, w_note, note currently expected.
- hit, output, 1, one-cycle pulse on a correct note.
- miss, output, 1, one-cycle pulse on a timeout.
- hits, output, w_score, saturating hit count.
- misses, output, w_score, saturating miss count.
- busy, output, 1, high in FETCH/LOAD/LISTEN/NEXT.
- done, output, 1, high in DONE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - rom_addr, cur_index, expected_note, hits, misses = 0.
  - hit, miss, busy, done = 0; timer=0; armed=0.
  - Outputs take these values immediately, with no clock edge required.
- States: IDLE, FETCH, LOAD, LISTEN, NEXT, DONE. All outputs are registered.
- IDLE:
  - start=1 → clear hits, misses and index; go to FETCH.
- FETCH: rom_addr=index; go to LOAD.
- LOAD:
  - expected_note<=rom_note; timer<=0; armed<=0.
  - rom_note==0 (rest entry) → NEXT directly; no hit, no miss.
  - Otherwise → LISTEN.
- LISTEN (timer increments each cycle):
  - det_note!=expected_note → armed<=1.
  - armed==1 && det_note==expected_note → hit=1 next cycle, hits+1, go to NEXT.
  - Else timer==timeout_cycles-1 → miss=1 next cycle, misses+1, go to NEXT.
  - Hit and timeout in the same cycle → hit only.
- Re-arm rule: det_note must differ from expected_note for at least 1 LISTEN cycle before a match counts. A held note therefore never satisfies consecutive identical entries.
- NEXT:
  - index==note_count-1 → DONE.
  - Else index+1 → FETCH.
  - Index never wraps.
- DONE:
  - done=1, busy=0.
  - start=1 → restart exactly as from IDLE.
- abort:
  - Highest priority: overrides start, hit and timeout in that cycle.
  - Next state is IDLE; pending hit/miss is not counted.
  - hits, misses, cur_index and expected_note hold their values.
- Counters saturate at all-ones and do not wrap.
- start while busy is ignored.
- Per-note overhead is 3 cycles (NEXT, FETCH, LOAD).
- Fastest note: 1 cycle release plus 1 cycle match in LISTEN.

Test Plan:
- Correct play. note_count=4, ROM {E,G,D,C}, start pulse. For each note, drive det_note=0 for 1 cycle, then the expected code. → 4 hit pulses, hits=4, misses=0, done=1, cur_index=3.
- Timeout. timeout_cycles=100, det_note=0 constant, ROM {E,G,D,C}. → Each miss pulse occurs exactly 100 cycles after LISTEN entry; misses=4, hits=0; done rises 4×103+1 cycles after start.
- Repeated note. ROM {E,E,G,C}, det_note held at 12'h080 (E) across note boundaries.
  - Initially → no hit, since E has not been released.
  - After a 0 gap and E again → hit for index 0.
  - Continuing to hold E → no hit for index 1 until another 0 gap; then hit.
- Rest skip. ROM {E,0,G,C}. → Index 1 passes through LOAD→NEXT in 2 cycles; hit/miss not asserted; totals cover 3 notes.
- Abort and restart.
  - Abort while at index 2 in LISTEN with hits=2 → IDLE next cycle, busy=0, hits=2 retained.
  - Abort in the same cycle as a matching det_note → no hit pulse.
  - Then start → hits=0, misses=0, rom_addr=0.
- Reset and saturation.
  - rst_n low mid-LISTEN → all outputs 0 asynchronously.
  - w_score=2 with 5 timeouts → misses sticks at 3.
